uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  UART transmit engine: consumer end of the TX memory interface handshake (tx_word/tx_loaded in, tx_state out).
//  Captures one word per tx_loaded rising edge; serialises start/data/parity/stop bits LSB-first onto txd.
//  tx_state encoding is what the TX buffer gates on: 2'd0 means idle and ready for the next word.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per UART bit (>=2)
//  DATA_BITS     8   data bits per frame, 5..9, taken from tx_word[DATA_BITS-1:0]
//  PARITY_EN     0   1 = append parity bit after data
//  PARITY_ODD    0   1 = odd parity, 0 = even (ignored if PARITY_EN=0)
//  STOP_BITS     1   stop bits, 1 or 2
// PORTS
//  clk        in   1   single clock; all logic on posedge clk
//  rst        in   1   synchronous, active-high reset
//  tx_ena     in   1   0 = abort/hold idle (same sense as TX buffer enable)
//  tx_word    in   10  word from TX buffer; only [DATA_BITS-1:0] used
//  tx_loaded  in   1   load strobe from TX buffer (may stay high >1 cycle)
//  tx_state   out  2   0 IDLE, 1 START, 2 DATA (incl. parity), 3 STOP
//  tx_done    out  1   1-cycle pulse when the last stop bit completes
//  txd        out  1   serial line, idle high
// BEHAVIOUR
//  - Reset (rst=1, sampled at posedge): txd=1, tx_state=0, tx_done=0, counters=0, shift reg=0, tx_loaded_d=0.
//    rst overrides tx_ena and any frame in progress.
//  - tx_ena=0 (rst=0): same clear as reset next edge; frame in flight is dropped, txd returns high at once.
//  - Load: IDLE & tx_ena & tx_loaded & ~tx_loaded_d (registered previous tx_loaded) -> capture
//    tx_word[DATA_BITS-1:0] into shift reg, compute parity = ^data ^ PARITY_ODD, go START.
//    Level-held tx_loaded never double-loads; tx_loaded outside IDLE is ignored (no queueing).
//  - Latency: load edge sampled at edge N -> txd=0, tx_state=1 visible after edge N.
//  - Baud counter: 0..CLKS_PER_BIT-1, reset to 0 on every state change; bit boundary when count==CLKS_PER_BIT-1.
//  - START: txd=0 for CLKS_PER_BIT cycles -> DATA, bit_idx=0.
//  - DATA: txd=shift[0]; at each boundary shift right, bit_idx++; after bit DATA_BITS-1 -> parity bit
//    (if PARITY_EN, one extra bit period, state stays 2) -> STOP.
//  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles; at final boundary -> IDLE with tx_done=1 that cycle.
//  - Frame length = CLKS_PER_BIT*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles, load edge to tx_done.
//  - Back-to-back: the TX buffer sees state 0 the cycle after tx_done; new rising tx_loaded accepted
//    from that cycle, so a new start bit may directly follow the stop bit (zero idle gap).
//  - bit_idx 4 bits, baud counter $clog2(CLKS_PER_BIT) bits; no wrap beyond terminal values.
//  - tx_done otherwise 0; asserted only on normal completion, never on abort.
// STRUCTURE
//  - uart_pkg: tx_state_t enum {TX_IDLE=2'd0, TX_START=2'd1, TX_DATA=2'd2, TX_STOP=2'd3}, UART_WORD_W=10.
//  - Sub-module uart_baud_counter (clk, rst, clear, tick): reused by the receiver later.
//  - Top: FSM, shift register, parity register, bit_idx, tx_loaded edge detector.
// TESTING  (CLKS_PER_BIT=4, DATA_BITS=8 unless stated)
//  1 Reset: hold rst 3 cycles mid-frame -> txd=1, tx_state=0, tx_done=0 next edge.
//  2 tx_word=10'h0A5, 2-cycle tx_loaded -> txd 0,1,0,1,0,0,1,0,1,1 each 4 cycles, tx_done at cycle 40, single frame.
//  3 PARITY_EN=1, PARITY_ODD=0, data 8'h07 -> parity bit 1; PARITY_ODD=1 -> 0; frame 44 cycles.
//  4 STOP_BITS=2, DATA_BITS=5, data 5'h1F -> stop high 8 cycles, tx_done at cycle 32.
//  5 Two words back-to-back (tx_loaded re-rises cycle after tx_done) -> second start bit begins
//    immediately after first stop bit; tx_loaded pulse mid-frame ignored.
//  6 tx_ena dropped mid-DATA -> txd=1, tx_state=0 next edge, no tx_done; re-enable and load sends clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: TX state encoding and TX buffer word width.
// Imported by the serializer, its interface and the bench.
package uart_pkg;

    localparam int UART_WORD_W = 10;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// TX buffer <-> serializer handshake bundle.
// master: TX buffer (drives enable, word, load strobe); slave: serializer.
interface uart_tx_serializer_if;
    import uart_pkg::*;

    logic                   tx_ena;
    logic [UART_WORD_W-1:0] tx_word;
    logic                   tx_loaded;
    logic [1:0]             tx_state;
    logic                   tx_done;

    modport master (
        output tx_ena, tx_word, tx_loaded,
        input  tx_state, tx_done
    );

    modport slave (
        input  tx_ena, tx_word, tx_loaded,
        output tx_state, tx_done
    );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, tick on the last count.
// Ports: clk, rst (sync high), clear (hold at 0), tick (bit boundary).
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Wraps to 0 at each boundary so every bit period restarts cleanly.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: loads a word on a rising tx_loaded and sends start/data/parity/stop LSB-first.
// Ports: clk, rst (sync high), bus (slave: tx_ena/tx_word/tx_loaded in, tx_state/tx_done out), txd (idle high).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_serializer_if.slave   bus,
    output logic                  txd
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    tx_state_t              state_q;
    logic                   txd_q;
    logic                   done_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic [3:0]             bit_idx_q;
    logic                   ld_q;

    logic                   tick;
    logic                   baud_clear;
    logic [DATA_BITS-1:0]   data;
    logic                   unused_word;

    assign data        = bus.tx_word[DATA_BITS-1:0];
    // Upper word bits are don't-care for narrow frames.
    assign unused_word = ^bus.tx_word;

    // Only IDLE needs an explicit clear; every other state change
    // happens on a tick, where the counter wraps to 0 by itself.
    assign baud_clear = (state_q == TX_IDLE) || !bus.tx_ena;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst || !bus.tx_ena) begin
            state_q   <= TX_IDLE;
            txd_q     <= 1'b1;
            done_q    <= 1'b0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_idx_q <= '0;
            ld_q      <= 1'b0;
        end else begin
            ld_q   <= bus.tx_loaded;
            done_q <= 1'b0;
            unique case (state_q)
                TX_IDLE: begin
                    if (bus.tx_loaded && !ld_q) begin
                        shift_q <= data;
                        par_q   <= (^data) ^ (PARITY_ODD != 0);
                        txd_q   <= 1'b0;
                        state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        state_q   <= TX_DATA;
                        bit_idx_q <= '0;
                        txd_q     <= shift_q[0];
                    end
                end
                TX_DATA: begin
                    // bit_idx == DATA_BITS marks the parity bit period.
                    if (tick) begin
                        if (bit_idx_q < LAST_DATA) begin
                            shift_q   <= shift_q >> 1;
                            txd_q     <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end else if (PARITY_EN != 0 && bit_idx_q == LAST_DATA) begin
                            txd_q     <= par_q;
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end else begin
                            state_q   <= TX_STOP;
                            txd_q     <= 1'b1;
                            bit_idx_q <= '0;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        if (bit_idx_q == LAST_STOP) begin
                            state_q <= TX_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx_state = state_q;
    assign bus.tx_done  = done_q;
    assign txd          = txd_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four parameter variants driven in parallel,
// checked every cycle against a frame-offset model plus literal expectations.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    localparam int CPB = 4;
    localparam int N   = 4;
    localparam int DB_T [N] = '{8, 8, 8, 5};
    localparam int PE_T [N] = '{0, 1, 1, 0};
    localparam int PO_T [N] = '{0, 0, 1, 0};
    localparam int SB_T [N] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       loaded;
    logic [9:0] word [N];
    logic [1:0] st [N];
    logic       dn [N];
    logic       tx [N];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            uart_tx_serializer_if bus ();
            assign bus.tx_ena    = ena;
            assign bus.tx_word   = word[g];
            assign bus.tx_loaded = loaded;
            assign st[g]         = bus.tx_state;
            assign dn[g]         = bus.tx_done;

            uart_tx_serializer #(
                .CLKS_PER_BIT(CPB),
                .DATA_BITS   (DB_T[g]),
                .PARITY_EN   (PE_T[g]),
                .PARITY_ODD  (PO_T[g]),
                .STOP_BITS   (SB_T[g])
            ) dut (
                .clk(clk),
                .rst(rst),
                .bus(bus.slave),
                .txd(tx[g])
            );
        end
    endgenerate

    task automatic chk(input string nm, input int k,
                       input logic [1:0] act, input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t",
                     nm, k, act, exp, $time);
        end
    endtask

    // Model: a frame is a list of line bits; output is bit (t / CPB)
    // where t counts cycles since the load edge.
    bit         m_act  [N];
    int         m_t    [N];
    logic [9:0] m_data [N];
    bit         m_ldp  [N];
    bit         m_done [N];

    function automatic int frame_bits(input int k);
        return 1 + DB_T[k] + PE_T[k] + SB_T[k];
    endfunction

    function automatic logic line_bit(input int k, input logic [9:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= DB_T[k]) return d[b-1];
        if (PE_T[k] != 0 && b == DB_T[k] + 1) return (^d) ^ (PO_T[k] != 0);
        return 1'b1;
    endfunction

    function automatic logic [1:0] state_of(input int k, input int t);
        int b;
        b = t / CPB;
        if (b == 0) return 2'd1;
        if (b <= DB_T[k] + PE_T[k]) return 2'd2;
        return 2'd3;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst || !ena) begin
                m_act[k]  = 0;
                m_ldp[k]  = 0;
                m_done[k] = 0;
            end else begin
                m_done[k] = 0;
                if (!m_act[k]) begin
                    if (loaded && !m_ldp[k]) begin
                        m_act[k]  = 1;
                        m_t[k]    = 0;
                        m_data[k] = word[k] & ((10'd1 << DB_T[k]) - 10'd1);
                    end
                end else begin
                    m_t[k]++;
                    if (m_t[k] == CPB * frame_bits(k)) begin
                        m_act[k]  = 0;
                        m_done[k] = 1;
                    end
                end
                m_ldp[k] = loaded;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            logic [1:0] es;
            logic       et;
            es = m_act[k] ? state_of(k, m_t[k]) : 2'd0;
            et = m_act[k] ? line_bit(k, m_data[k], m_t[k] / CPB) : 1'b1;
            chk("state", k, st[k], es);
            chk("txd", k, {1'b0, tx[k]}, {1'b0, et});
            chk("done", k, {1'b0, dn[k]}, {1'b0, m_done[k]});
        end
    end

    logic       cap [N][64];
    int         first_done [N];
    int         ndone [N];
    logic [9:0] exp_a;
    int         hi_cnt;
    int         w;

    task automatic idle_lits(input string nm);
        for (int k = 0; k < N; k++) begin
            chk({nm, "_state"}, k, st[k], 2'd0);
            chk({nm, "_txd"}, k, {1'b0, tx[k]}, 2'd1);
            chk({nm, "_done"}, k, {1'b0, dn[k]}, 2'd0);
        end
    endtask

    task automatic pulse_load(input int n);
        loaded = 1'b1;
        repeat (n) @(negedge clk);
        loaded = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        loaded = 1'b0;
        for (int k = 0; k < N; k++) word[k] = '0;
        repeat (3) @(negedge clk);
        idle_lits("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single directed frame on every variant, 2-cycle load strobe.
        word[0] = 10'h0A5;
        word[1] = 10'h007;
        word[2] = 10'h007;
        word[3] = 10'h3FF;
        for (int k = 0; k < N; k++) begin
            first_done[k] = -1;
            ndone[k]      = 0;
        end
        loaded = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                cap[k][c] = tx[k];
                if (dn[k] === 1'b1) begin
                    ndone[k]++;
                    if (first_done[k] < 0) first_done[k] = c;
                end
            end
            if (c == 1) loaded = 1'b0;
        end
        exp_a = 10'b1101001010;
        for (int i = 0; i < 10; i++) begin
            chk("a5_bit_lo", i, {1'b0, cap[0][4*i]}, {1'b0, exp_a[i]});
            chk("a5_bit_hi", i, {1'b0, cap[0][4*i+3]}, {1'b0, exp_a[i]});
        end
        chk("a5_done_cyc", 0, 2'(first_done[0] == 40), 2'd1);
        chk("par_done_cyc", 1, 2'(first_done[1] == 44), 2'd1);
        chk("par_done_cyc", 2, 2'(first_done[2] == 44), 2'd1);
        chk("s2_done_cyc", 3, 2'(first_done[3] == 32), 2'd1);
        for (int k = 0; k < N; k++) chk("one_frame", k, 2'(ndone[k]), 2'd1);
        chk("even_par", 1, {1'b0, cap[1][36]}, 2'd1);
        chk("odd_par", 2, {1'b0, cap[2][36]}, 2'd0);
        hi_cnt = 0;
        for (int c = 24; c < 32; c++) if (cap[3][c] === 1'b1) hi_cnt++;
        chk("s2_stop_hi", 3, 2'(hi_cnt == 8), 2'd1);

        // Reset held 3 cycles in the middle of a frame.
        word[0] = 10'h13C;
        pulse_load(1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        idle_lits("midrst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Back-to-back frames plus an ignored mid-frame strobe.
        word[0] = 10'h05A;
        pulse_load(2);
        w = 0;
        while (dn[0] !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("b2b_wait", 0, 2'(w < 100), 2'd1);
        word[0] = 10'h0C3;
        loaded  = 1'b1;
        @(negedge clk);
        chk("b2b_start_st", 0, st[0], 2'd1);
        chk("b2b_start_txd", 0, {1'b0, tx[0]}, 2'd0);
        loaded = 1'b0;
        repeat (14) @(negedge clk);
        pulse_load(1);
        ndone[0] = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dn[0] === 1'b1) ndone[0]++;
        end
        chk("b2b_frames", 0, 2'(ndone[0]), 2'd1);
        repeat (10) @(negedge clk);

        // Enable dropped mid-DATA: frame discarded, no done.
        word[0] = 10'h0FF;
        pulse_load(2);
        repeat (12) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        idle_lits("abort");
        ena = 1'b1;
        ndone[0] = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (dn[0] === 1'b1) ndone[0]++;
        end
        chk("abort_nodone", 0, 2'(ndone[0]), 2'd0);
        word[0] = 10'h081;
        pulse_load(2);
        ndone[0] = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (dn[0] === 1'b1) ndone[0]++;
        end
        chk("reenable_done", 0, 2'(ndone[0]), 2'd1);

        // Randomised traffic with occasional abort and reset.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) loaded = ~loaded;
            ena = ($urandom_range(0, 399) != 0);
            rst = ($urandom_range(0, 699) == 0);
            for (int k = 0; k < N; k++) word[k] = 10'($urandom);
            @(negedge clk);
        end
        rst    = 1'b0;
        ena    = 1'b1;
        loaded = 1'b0;
        repeat (60) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
